sm_dmem_arbiter: RTL



---
 rtl/sm_dmem_arbiter_pkg.sv | 17 +
 rtl/sm_dmem_arbiter_rr_arb2.sv | 55 +++++
 rtl/sm_dmem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sm_dmem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sm_dmem_arbiter_pkg
// Shared constants for the data-memory arbiter slice:
//   - FSM state encodings (IDLE / ISSUE / WAIT)
//   - requester IDs (CPU / DBG), also used as the bit index into req/gnt
// No ports; imported by sm_rr_arb2 and sm_dmem_arbiter.
// ----------------------------------------------------------------------------
package sm_dmem_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;

   localparam logic ARB_ID_CPU = 1'b0;
   localparam logic ARB_ID_DBG = 1'b1;

endpackage

// File: rtl/sm_dmem_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// sm_rr_arb2
// Combinational two-way picker for the data-memory arbiter.
// Bit 0 of req/gnt is the CPU, bit 1 is the debug loader.
//
// Ports:
//   i_req[1:0]  request vector
//   i_last      ID of the requester granted most recently
//   i_enable    gnt may only be asserted while this is high
//   o_gnt[1:0]  one-hot grant (zero when disabled or no request)
//   o_winner    ID of the requester that would be granted
//
// Configuration macro: SM_DMEM_ARB_FIXED_PRIO_EN
//   defined   : CPU always wins; i_last is ignored
//   undefined : round-robin, a tie goes to the requester not granted last
// ----------------------------------------------------------------------------
module sm_rr_arb2
   import sm_dmem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_enable,
   output logic [1:0] o_gnt,
   output logic       o_winner
);

   logic w_winner;

   // Winner selection: the sole requester, otherwise the tie-break rule.
   always_comb begin
      w_winner = ARB_ID_CPU;
`ifdef SM_DMEM_ARB_FIXED_PRIO_EN
      if (!i_req[ARB_ID_CPU] && i_req[ARB_ID_DBG]) begin
         w_winner = ARB_ID_DBG;
      end
`else
      if (i_req == 2'b11) begin
         w_winner = ~i_last;
      end else if (i_req[ARB_ID_DBG]) begin
         w_winner = ARB_ID_DBG;
      end
`endif
   end

   // One-hot grant, only when enabled and somebody is asking.
   always_comb begin
      o_gnt = 2'b00;
      if (i_enable && (|i_req)) begin
         o_gnt[w_winner] = 1'b1;
      end
   end

   assign o_winner = w_winner;

endmodule

// File: rtl/sm_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// sm_dmem_arbiter
// Shares the single synchronous-read data RAM port between the CPU load/store
// path and the debug/DMA loader. One access at a time:
//   IDLE  -> grant (combinational gnt pulse), capture the request
//   ISSUE -> drive the RAM; writes finish here, reads go on to WAIT
//   WAIT  -> RAM read data is valid, latch it for the winner
// done pulses are registered, one cycle after ISSUE (write) or WAIT (read).
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_cpu_* / o_cpu_*            CPU requester: req/we/addr/wdata in,
//                                gnt/done/rdata out
//   i_dbg_* / o_dbg_*            debug requester, same meaning
//   o_ram_addr/o_ram_we/o_ram_wdata, i_ram_rdata   RAM side (1-cycle read)
//   o_busy                       high in ISSUE and WAIT
//
// Configuration macro: SM_DMEM_ARB_FIXED_PRIO_EN (strict CPU priority,
// handled inside sm_rr_arb2; default build is round-robin).
// ----------------------------------------------------------------------------
module sm_dmem_arbiter
   import sm_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_done,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_gnt,
   output logic              o_dbg_done,
   output logic [DATA_W-1:0] o_dbg_rdata,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_busy
);

   logic [1:0]        r_state;
   logic              r_capWe;
   logic [ADDR_W-1:0] r_capAddr;
   logic [DATA_W-1:0] r_capWdata;
   logic              r_capId;
   logic              r_lastGrant;
   logic              r_cpuDone;
   logic              r_dbgDone;
   logic [DATA_W-1:0] r_cpuRdata;
   logic [DATA_W-1:0] r_dbgRdata;

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_winner;
   logic              w_idle;

   assign w_req  = {i_dbg_req, i_cpu_req};
   assign w_idle = (r_state == ARB_IDLE);

   // Grants are only offered from IDLE, so gnt never appears in ISSUE/WAIT.
   sm_rr_arb2 u_arb (
      .i_req    (w_req),
      .i_last   (r_lastGrant),
      .i_enable (w_idle),
      .o_gnt    (w_gnt),
      .o_winner (w_winner)
   );

   // Sequencer, capture registers, done pulses and per-requester read data.
   // The capture registers double as the RAM address/data drivers: they only
   // change on a grant, so the RAM bus naturally holds its last value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ARB_IDLE;
         r_capWe     <= 1'b0;
         r_capAddr   <= '0;
         r_capWdata  <= '0;
         r_capId     <= ARB_ID_CPU;
         r_lastGrant <= ARB_ID_DBG;
         r_cpuDone   <= 1'b0;
         r_dbgDone   <= 1'b0;
         r_cpuRdata  <= '0;
         r_dbgRdata  <= '0;
      end else begin
         r_cpuDone <= 1'b0;
         r_dbgDone <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (|w_req) begin
                  r_capId     <= w_winner;
                  r_lastGrant <= w_winner;
                  if (w_winner == ARB_ID_DBG) begin
                     r_capWe    <= i_dbg_we;
                     r_capAddr  <= i_dbg_addr;
                     r_capWdata <= i_dbg_wdata;
                  end else begin
                     r_capWe    <= i_cpu_we;
                     r_capAddr  <= i_cpu_addr;
                     r_capWdata <= i_cpu_wdata;
                  end
                  r_state <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (r_capWe) begin
                  r_cpuDone <= (r_capId == ARB_ID_CPU);
                  r_dbgDone <= (r_capId == ARB_ID_DBG);
                  r_state   <= ARB_IDLE;
               end else begin
                  r_state <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (r_capId == ARB_ID_DBG) begin
                  r_dbgRdata <= i_ram_rdata;
                  r_dbgDone  <= 1'b1;
               end else begin
                  r_cpuRdata <= i_ram_rdata;
                  r_cpuDone  <= 1'b1;
               end
               r_state <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Write enable is derived from the state so an async reset drops it at once.
   assign o_ram_we    = (r_state == ARB_ISSUE) && r_capWe;
   assign o_ram_addr  = r_capAddr;
   assign o_ram_wdata = r_capWdata;

   assign o_cpu_gnt   = w_gnt[ARB_ID_CPU];
   assign o_dbg_gnt   = w_gnt[ARB_ID_DBG];
   assign o_cpu_done  = r_cpuDone;
   assign o_dbg_done  = r_dbgDone;
   assign o_cpu_rdata = r_cpuRdata;
   assign o_dbg_rdata = r_dbgRdata;
   assign o_busy      = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT);

endmodule
